bicubic_tap_sched: RTL and testbench
====================================

Name: bicubic_tap_sched

Overview:
- Sequences the shared 3-input multiplier (mul_3 datapath: result = a*b*c, unsigned) over the 16 taps of one bicubic output pixel.
- Takes one tap per handshake: pixel term a, weights b and c, and a sign flag. Drives the multiplier operands and tracks in-flight products through its fixed pipeline latency.
- Accumulates the signed sum and presents one result per pixel with valid/ready backpressure.
- Sits between the window/weight generator and the output normaliser.

Parameters:
- TAPS, 16: taps per output pixel.
- A_W, 18: width of operand a.
- BC_W, 10: width of operands b and c.
- P_W, 38: multiplier product width (A_W + 2*BC_W).
- MUL_LAT, 2: multiplier latency in cycles, from sampling its inputs to a valid result.
- ACC_W, 43: signed accumulator/output width (P_W + log2(TAPS) + 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tap_valid  in  1  tap presented
- tap_ready  out  1  scheduler accepts tap
- tap_a  in  A_W  pixel operand
- tap_b  in  BC_W  x weight magnitude
- tap_c  in  BC_W  y weight magnitude
- tap_neg  in  1  1 = subtract this product
- tap_last  in  1  final tap of pixel
- mul_a  out  A_W  multiplier operand a (registered)
- mul_b  out  BC_W  multiplier operand b (registered)
- mul_c  out  BC_W  multiplier operand c (registered)
- mul_result  in  P_W  multiplier product
- out_valid  out  1  pixel sum valid
- out_ready  in  1  downstream accepts
- out_data  out  ACC_W  signed pixel sum
- out_err  out  1  tap count was not TAPS

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=ACCUM, tap counter=0, accumulator=0.
  - Product-valid pipeline cleared.
  - mul_a/mul_b/mul_c=0, out_valid=0, out_data=0, out_err=0.
  - In-flight multiplier products are discarded; the multiplier itself is not reset.
- tap_ready is combinational: 1 iff state==ACCUM and rst==0.
- Accepting a tap at edge k (tap_valid & tap_ready):
  - Registers tap_a/b/c into mul_a/b/c.
  - Pushes valid=1 and the neg flag into a tracking shift register of depth MUL_LAT+1.
  - Increments the tap counter.
- Cycles with no accept: mul_a/b/c are driven to 0 and valid=0 is pushed.
- Pipeline timing: the multiplier samples operands at edge k+1 and mul_result is valid after edge k+MUL_LAT.
- Accumulation at edge k+MUL_LAT+1 (edge k+3 by default):
  - acc <= acc + zero-extended mul_result, or acc - mul_result if neg=1.
  - Signed two's complement, no saturation. ACC_W guarantees no overflow for TAPS maximal products.
- States:
  - ACCUM: accepts taps. An accepted tap with tap_last=1, or the TAPS-th accepted tap, moves to DRAIN.
    - out_err is latched as (tap_last=1 with count≠TAPS-1) or (TAPS-th tap with tap_last=0).
    - In the forced case the TAPS-th tap is treated as last; the next tap starts a new pixel.
  - DRAIN: tap_ready=0; waits until the tracking pipeline is empty.
    - At the edge of the final accumulation (k+MUL_LAT+1): out_valid<=1, out_data<=final sum, go to HOLD.
  - HOLD: out_valid=1; out_data and out_err are held stable; tap_ready=0.
    - On out_valid & out_ready: out_valid<=0, acc<=0, counter<=0, go to ACCUM.
    - tap_ready returns high the following cycle.
- Latency:
  - Last tap accepted at edge k → out_valid high after edge k+MUL_LAT+1.
  - Minimum pixel period is TAPS+MUL_LAT+2 cycles.
- Gaps in tap_valid are allowed; the result is independent of bubble placement.
- tap_* inputs are ignored whenever tap_ready=0.
- rst asserted during DRAIN or HOLD aborts the pixel; no output is produced for it.

Test Plan:
- 16 taps a=1000, b=512, c=512, neg=0, back-to-back, out_ready=1 → out_data=4194304000, out_err=0; out_valid rises 3 cycles after last accept and lasts 1 cycle.
- Tap0 a=262143, b=c=1023, neg=1, taps 1–15 all zero → out_data=-274340251647. Second pixel: taps 0–7 neg=0, taps 8–15 neg=1, all a=b=c=7 → out_data=0.
- out_ready=0 for 10 cycles after out_valid, tap_valid held 1 → out_data/out_valid stable, tap_ready=0, no tap consumed. After the handshake, tap_ready=1 next cycle; next pixel of 16 taps of 1*1*1 → 16 (accumulator was cleared).
- tap_last on the 6th tap (all 1*1*1) → out_data=6, out_err=1. Then 17 taps with no tap_last → first pixel out_data=16, out_err=1; the 17th tap begins the next pixel.
- rst pulsed for 1 cycle after 7 taps accepted → all outputs 0; tap_ready=1 the cycle after rst falls. Following 16 taps of 2*3*4 → out_data=384, no residue from the aborted pixel.
- 16 taps of 5*5*5 with random 0–3 cycle bubbles → out_data=2000, identical to the back-to-back run.

Source files
------------

// File: rtl/bicubic_tap_sched.sv
// Schedules the 16 taps of one bicubic output pixel through the shared a*b*c multiplier.
// It tracks each product through the multiplier latency and accumulates a signed pixel sum.
module bicubic_tap_sched #(
  parameter int TAPS    = 16,
  parameter int A_W     = 18,
  parameter int BC_W    = 10,
  parameter int P_W     = 38,
  parameter int MUL_LAT = 2,
  parameter int ACC_W   = 43
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tap_valid,
  output logic                    tap_ready,
  input  logic [A_W-1:0]          tap_a,
  input  logic [BC_W-1:0]         tap_b,
  input  logic [BC_W-1:0]         tap_c,
  input  logic                    tap_neg,
  input  logic                    tap_last,
  output logic [A_W-1:0]          mul_a,
  output logic [BC_W-1:0]         mul_b,
  output logic [BC_W-1:0]         mul_c,
  input  logic [P_W-1:0]          mul_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_err
);

  // state | meaning
  // ACCUM | accepting taps, products of earlier taps still accumulating
  // DRAIN | last tap taken, waiting for its product to land
  // HOLD  | pixel sum presented until downstream takes it
  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  localparam int CNT_W = $clog2(TAPS + 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]        tap_cnt;
  logic [MUL_LAT:0]        pipe_vld;
  logic [MUL_LAT:0]        pipe_neg;
  logic signed [ACC_W-1:0] acc;
  logic                    err_pend;

  logic                    accept;
  logic                    forced_last;
  logic                    last_tap;
  logic                    tap_err;
  logic                    prod_vld;
  logic                    prod_neg;
  logic                    pipe_busy;
  logic                    final_acc;
  logic                    out_fire;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_sum;

  assign tap_ready   = (state == ACCUM) && !rst;
  assign accept      = tap_valid && tap_ready;
  assign forced_last = (tap_cnt == CNT_W'(TAPS - 1));
  assign last_tap    = accept && (tap_last || forced_last);
  // Error when the pixel ends early, or when the count runs out without tap_last.
  assign tap_err     = tap_last ^ forced_last;

  assign prod_vld  = pipe_vld[MUL_LAT];
  assign prod_neg  = pipe_neg[MUL_LAT];
  assign pipe_busy = |pipe_vld[MUL_LAT-1:0];
  assign final_acc = (state == DRAIN) && prod_vld && !pipe_busy;
  assign out_fire  = out_valid && out_ready;

  assign prod_ext = $signed({{(ACC_W-P_W){1'b0}}, mul_result});
  assign acc_sum  = prod_neg ? (acc - prod_ext) : (acc + prod_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (last_tap)  state_nxt = DRAIN;
      DRAIN: if (final_acc) state_nxt = HOLD;
      HOLD:  if (out_fire)  state_nxt = ACCUM;
      default:              state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a     <= '0;
      mul_b     <= '0;
      mul_c     <= '0;
      pipe_vld  <= '0;
      pipe_neg  <= '0;
      tap_cnt   <= '0;
      acc       <= '0;
      err_pend  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      // Idle cycles feed zeros so the multiplier never sees stale operands.
      mul_a    <= accept ? tap_a : '0;
      mul_b    <= accept ? tap_b : '0;
      mul_c    <= accept ? tap_c : '0;
      pipe_vld <= {pipe_vld[MUL_LAT-1:0], accept};
      pipe_neg <= {pipe_neg[MUL_LAT-1:0], accept && tap_neg};

      if (accept) begin
        tap_cnt <= tap_cnt + CNT_W'(1);
      end
      if (last_tap) begin
        err_pend <= tap_err;
      end

      if (prod_vld) begin
        acc <= acc_sum;
      end

      if (final_acc) begin
        out_valid <= 1'b1;
        out_data  <= acc_sum;
        out_err   <= err_pend;
      end

      if (out_fire) begin
        out_valid <= 1'b0;
        acc       <= '0;
        tap_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bicubic_tap_sched.sv
// Directed bench for bicubic_tap_sched with a behavioural two-stage a*b*c multiplier.
module tb_bicubic_tap_sched;

  localparam int A_W   = 18;
  localparam int BC_W  = 10;
  localparam int P_W   = 38;
  localparam int ACC_W = 43;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    tap_valid;
  logic                    tap_ready;
  logic [A_W-1:0]          tap_a;
  logic [BC_W-1:0]         tap_b;
  logic [BC_W-1:0]         tap_c;
  logic                    tap_neg;
  logic                    tap_last;
  logic [A_W-1:0]          mul_a;
  logic [BC_W-1:0]         mul_b;
  logic [BC_W-1:0]         mul_c;
  logic [P_W-1:0]          mul_result;
  logic [P_W-1:0]          mul_s1;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_err;

  int total = 0;
  int bad   = 0;
  int lost  = 0;
  int cyc   = 0;

  bicubic_tap_sched dut (
    .clk(clk), .rst(rst),
    .tap_valid(tap_valid), .tap_ready(tap_ready),
    .tap_a(tap_a), .tap_b(tap_b), .tap_c(tap_c),
    .tap_neg(tap_neg), .tap_last(tap_last),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Latency-2 multiplier, deliberately without reset.
  always @(posedge clk) begin
    mul_s1     <= P_W'(mul_a) * P_W'(mul_b) * P_W'(mul_c);
    mul_result <= mul_s1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tap(input logic [A_W-1:0] a, input logic [BC_W-1:0] b,
                          input logic [BC_W-1:0] c, input logic neg, input logic last);
    int n = 0;
    tap_valid = 1'b1;
    tap_a = a; tap_b = b; tap_c = c; tap_neg = neg; tap_last = last;
    while (!tap_ready && n < 100) begin
      step();
      n++;
    end
    if (tap_ready) step();
    else lost++;
    tap_valid = 1'b0;
  endtask

  task automatic wait_out(output logic seen);
    int n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    seen = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++;
    if (tap_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst: got %0b expected 0", tap_ready); end
    rst = 1'b0;
    #1;
    total++;
    if ({mul_a, mul_b, mul_c} !== '0) begin bad++; $display("FAIL reset_mul: got %0d/%0d/%0d expected 0", mul_a, mul_b, mul_c); end
    total++;
    if ({out_valid, out_err} !== 2'b00 || out_data !== '0) begin
      bad++; $display("FAIL reset_out: got v=%0b e=%0b d=%0d expected 0", out_valid, out_err, out_data);
    end
    total++;
    if (tap_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b expected 1", tap_ready); end
  endtask

  task automatic test_back_to_back();
    int k;
    logic seen;
    for (int i = 0; i < 16; i++) begin
      send_tap(18'd1000, 10'd512, 10'd512, 1'b0, i == 15);
      if (i == 0) begin
        total++;
        if (mul_a !== 18'd1000 || mul_b !== 10'd512) begin
          bad++; $display("FAIL b2b_operand: got a=%0d b=%0d expected 1000/512", mul_a, mul_b);
        end
      end
    end
    k = cyc;
    wait_out(seen);
    total++;
    if (!seen) begin bad++; $display("FAIL b2b_timeout: got no out_valid expected out_valid"); end
    total++;
    if (cyc !== k + 3) begin bad++; $display("FAIL b2b_latency: got %0d expected %0d", cyc - k, 3); end
    total++;
    if (out_data !== 43'sd4194304000 || out_err !== 1'b0) begin
      bad++; $display("FAIL b2b_data: got %0d err=%0b expected 4194304000 err=0", out_data, out_err);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse: got %0b expected 0", out_valid); end
  endtask

  task automatic test_signed();
    logic seen;
    logic signed [ACC_W-1:0] exp_neg;
    exp_neg = -43'sd274340251647;
    send_tap(18'd262143, 10'd1023, 10'd1023, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) send_tap('0, '0, '0, 1'b0, i == 15);
    wait_out(seen);
    total++;
    if (!seen || out_data !== exp_neg) begin
      bad++; $display("FAIL signed_max_neg: got %0d expected %0d", out_data, exp_neg);
    end
    step();
    for (int i = 0; i < 16; i++) send_tap(18'd7, 10'd7, 10'd7, i >= 8, i == 15);
    wait_out(seen);
    total++;
    if (!seen || out_data !== '0 || out_err !== 1'b0) begin
      bad++; $display("FAIL signed_cancel: got %0d err=%0b expected 0 err=0", out_data, out_err);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic seen;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_tap(18'd2, 10'd1, 10'd1, 1'b0, i == 15);
    wait_out(seen);
    tap_valid = 1'b1;
    tap_a = 18'd99; tap_b = 10'd1; tap_c = 10'd1; tap_neg = 1'b0; tap_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 43'sd32 || tap_ready !== 1'b0 || mul_a !== '0) begin
        bad++;
        $display("FAIL bp_hold: got v=%0b d=%0d rdy=%0b mul_a=%0d expected v=1 d=32 rdy=0 mul_a=0",
                 out_valid, out_data, tap_ready, mul_a);
      end
      step();
    end
    tap_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0 || tap_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: got v=%0b rdy=%0b expected v=0 rdy=1", out_valid, tap_ready);
    end
    for (int i = 0; i < 16; i++) send_tap(18'd1, 10'd1, 10'd1, 1'b0, i == 15);
    wait_out(seen);
    total++;
    if (!seen || out_data !== 43'sd16) begin
      bad++; $display("FAIL bp_next_pixel: got %0d expected 16", out_data);
    end
    step();
  endtask

  task automatic test_tap_count_err();
    logic seen;
    for (int i = 0; i < 6; i++) send_tap(18'd1, 10'd1, 10'd1, 1'b0, i == 5);
    wait_out(seen);
    total++;
    if (!seen || out_data !== 43'sd6 || out_err !== 1'b1) begin
      bad++; $display("FAIL err_short: got %0d err=%0b expected 6 err=1", out_data, out_err);
    end
    step();
    for (int i = 0; i < 16; i++) send_tap(18'd1, 10'd1, 10'd1, 1'b0, 1'b0);
    wait_out(seen);
    total++;
    if (!seen || out_data !== 43'sd16 || out_err !== 1'b1) begin
      bad++; $display("FAIL err_forced: got %0d err=%0b expected 16 err=1", out_data, out_err);
    end
    send_tap(18'd1, 10'd1, 10'd1, 1'b0, 1'b1);
    wait_out(seen);
    total++;
    if (!seen || out_data !== 43'sd1 || out_err !== 1'b1) begin
      bad++; $display("FAIL err_17th_new_pixel: got %0d err=%0b expected 1 err=1", out_data, out_err);
    end
    step();
  endtask

  task automatic test_reset_abort();
    logic seen;
    for (int i = 0; i < 7; i++) send_tap(18'd1, 10'd1, 10'd1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if (tap_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_in_rst: got %0b expected 0", tap_ready); end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (mul_a !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0 || tap_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_clear: got mul_a=%0d v=%0b d=%0d e=%0b rdy=%0b expected 0/0/0/0/1",
               mul_a, out_valid, out_data, out_err, tap_ready);
    end
    for (int i = 0; i < 16; i++) send_tap(18'd2, 10'd3, 10'd4, 1'b0, i == 15);
    wait_out(seen);
    total++;
    if (!seen || out_data !== 43'sd384 || out_err !== 1'b0) begin
      bad++; $display("FAIL abort_next_pixel: got %0d err=%0b expected 384 err=0", out_data, out_err);
    end
    step();
  endtask

  task automatic test_bubbles();
    logic seen;
    for (int i = 0; i < 16; i++) begin
      send_tap(18'd5, 10'd5, 10'd5, 1'b0, i == 15);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_out(seen);
    total++;
    if (!seen || out_data !== 43'sd2000 || out_err !== 1'b0) begin
      bad++; $display("FAIL bubbles: got %0d err=%0b expected 2000 err=0", out_data, out_err);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    tap_valid = 1'b0;
    tap_a = '0; tap_b = '0; tap_c = '0; tap_neg = 1'b0; tap_last = 1'b0;
    out_ready = 1'b1;
    #1;
    test_reset();
    test_back_to_back();
    test_signed();
    test_backpressure();
    test_tap_count_err();
    test_reset_abort();
    test_bubbles();
    total++;
    if (lost !== 0) begin bad++; $display("FAIL tap_accept_timeout: got %0d expected 0", lost); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
